// File: rtl/load_store_unit.sv
// load_store_unit: memory stage with a single-outstanding valid/grant data port and load extension.
// Rev 1.0 | optional MISALIGN_TRAP_EN traps misaligned half/word accesses without touching memory.
`default_nettype none

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RD_W           = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            mem_r,
  input  logic            mem_w,
  input  logic [2:0]      funct3,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic [RD_W-1:0] rd_in,
  output logic            stall,
  output logic            resp_valid,
  output logic [31:0]     resp_rdata,
  output logic [RD_W-1:0] resp_rd,
  output logic            bus_err,
  output logic            misalign_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [31:0]     dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [31:0]     dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [31:0]     dmem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [2:0]        f3_q;
  logic              we_q, berr_q, merr_q;
  logic [RD_W-1:0]   rd_q;

  logic any_op, bad_op, legal_f3, misaligned, timeout;
  logic [31:0] ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign any_op   = req_valid && (mem_r || mem_w);
  assign legal_f3 = mem_w ? (funct3 <= 3'b010)
                          : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign bad_op   = (mem_r && mem_w) || !legal_f3;
  assign timeout  = cnt >= CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (any_op) state_nx = (bad_op || misaligned) ? RESP : REQ;
      REQ:  if (dmem_gnt) state_nx = we_q ? RESP : WAIT;
            else if (timeout) state_nx = RESP;
      WAIT: if (dmem_rvalid || timeout) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane extraction from the returned word using the captured address and width.
  assign ld_byte = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_val = 32'd0;
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_val = dmem_rdata;
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      berr_q  <= 1'b0;
      merr_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state)
        IDLE: if (any_op) begin
          addr_q  <= addr;
          wdata_q <= wdata;
          f3_q    <= funct3;
          we_q    <= mem_w;
          rd_q    <= rd_in;
          cnt     <= '0;
          rdata_q <= '0;
          berr_q  <= bad_op;
          merr_q  <= !bad_op && misaligned;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (!dmem_gnt && timeout) berr_q <= 1'b1;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (dmem_rvalid)  rdata_q <= ld_val;
          else if (timeout) berr_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (state == IDLE);
  assign stall        = (state != IDLE) || any_op;
  assign resp_valid   = (state == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_rd      = rd_q;
  assign bus_err      = resp_valid && berr_q;
  assign misalign_err = resp_valid && merr_q;

  assign dmem_req  = (state == REQ);
  assign dmem_we   = dmem_req && we_q;
  assign dmem_addr = dmem_req ? {addr_q[31:2], 2'b00} : 32'd0;

  always_comb begin
    dmem_be    = 4'd0;
    dmem_wdata = 32'd0;
    if (dmem_req) begin
      case (f3_q[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << addr_q[1:0];
          dmem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << {addr_q[1], 1'b0};
          dmem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = wdata_q;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the pipeline, directly downstream of decode/execute.
- Consumes the MemR/MemW controls from the decode bundle, the funct3 load/store width (load_type_t encodings), the ALU-computed address, the store data and the destination register index.
- Drives a single-outstanding valid/grant data-memory port with byte enables.
- Returns sign/zero-extended load data toward writeback, holding the pipeline stalled while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in REQ+WAIT before the transaction is abandoned with bus_err.
- RD_W, 5: width of the destination-register tag passed through.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  execute presents an operation
- req_ready  out  1  unit can accept an operation (state IDLE)
- mem_r  in  1  load (MemR)
- mem_w  in  1  store (MemW)
- funct3  in  3  width/sign: loads per load_type_t; stores 000=SB, 001=SH, 010=SW
- addr  in  32  byte address
- wdata  in  32  store data, rs2
- rd_in  in  RD_W  destination tag
- stall  out  1  hold upstream stages
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_rd  out  RD_W  tag of the completing operation
- bus_err  out  1  valid with resp_valid: illegal funct3, mem_r&mem_w, or timeout
- misalign_err  out  1  valid with resp_valid; see Optional Feature
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word

Behaviour:
- Reset: state IDLE; timeout counter 0; all registered outputs 0. dmem_req, resp_valid, bus_err and misalign_err are therefore 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid with exactly one of mem_r/mem_w set and a legal funct3: register addr/wdata/funct3/rd/op and go to REQ.
  - With neither bit set: no action.
  - With both bits set, or illegal funct3 (load 011/110/111, store >010): go to RESP with bus_err=1; no bus activity.
- REQ:
  - dmem_req=1; dmem_addr, dmem_we, dmem_be and dmem_wdata are stable until dmem_gnt.
  - On gnt: a store goes to RESP; a load goes to WAIT.
- WAIT:
  - On dmem_rvalid: capture the extracted, extended data and go to RESP.
  - rvalid is never in the same cycle as gnt; rvalid seen in REQ or IDLE is ignored.
- RESP: resp_valid=1 for exactly one cycle with resp_rd and the error flags, then IDLE.
- stall = (state != IDLE) || (req_valid && (mem_r || mem_w)). The stall therefore deasserts in the RESP→IDLE cycle.
- Latency with zero wait states:
  - Store: accept at cycle 0, gnt at cycle 1, resp_valid at cycle 2.
  - Load: accept at cycle 0, gnt at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], data={4{wdata[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, data={2{wdata[15:0]}}.
  - SW: be=4'b1111.
- Load dmem_be: same rule as the store lanes.
- Load extraction:
  - LB/LBU take the byte selected by addr[1:0].
  - LH/LHU take the half selected by addr[1].
  - LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout:
  - Counter clears on entry to REQ and increments each REQ/WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without completion: drop dmem_req and go to RESP with bus_err=1 and rdata 0.
- Reset mid-transaction: immediate return to IDLE, outputs cleared. A late gnt/rvalid after reset is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, is not issued to memory.
  - The unit goes IDLE→RESP with misalign_err=1 and resp_rdata=0.
- Undefined:
  - misalign_err is tied 0.
  - Low address bits below the natural alignment are ignored (SH uses addr[1]; SW ignores addr[1:0]).

Test Plan:
- SB addr=0x1003 wdata=0xA5 -> dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x1000; resp_valid 2 cycles after accept with zero-wait gnt.
- LB addr=0x2001, dmem_rdata=0x0000_80FF -> resp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH addr=0x2002, rdata=0x8001_0000, gnt delayed 3 cycles -> dmem_req held with stable outputs; resp_rdata=0xFFFF8001; stall high throughout.
- Load, gnt given, rvalid never -> resp_valid with bus_err=1 after TIMEOUT_CYCLES; dmem_req=0 afterwards. funct3=011 load -> bus_err with no dmem_req.
- rst_n low while in WAIT -> all outputs 0 immediately; a subsequent rvalid produces no resp_valid.
- With MISALIGN_TRAP_EN: LW addr=0x3002 -> no dmem_req, misalign_err=1 on resp_valid. Without it: dmem_addr=0x3000, full word returned.
